// File: rtl/axil_wr_slave_if.sv
// AXI4-Lite write channels (AW, W, B) between an interconnect master and a
// register-block slave.
interface axil_wr_slave_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output awready, wready, bresp, bvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axil_wr_slave.sv
// AXI4-Lite write-path slave terminating in a word register bank.
// Optional AXIL_WSTRB_EN: honour wstrb byte lanes on legal writes.
module axil_wr_slave #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    axil_wr_slave_if.slave                 bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                  state, state_d;
    logic                    aw_held, aw_held_d;
    logic                    w_held, w_held_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;

    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]     reg_we;
    logic [DATA_WIDTH-1:0]   wmask;
    logic [IDX_W-1:0]        idx;
    logic                    legal;

`ifdef AXIL_WSTRB_EN
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
`endif

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;

    // Address decode on the held AW: word aligned and inside the bank.
    assign idx   = awaddr_q[ADDR_WIDTH-1:2];
    assign legal = (awaddr_q[1:0] == 2'b00) && (32'(idx) < NUM_REGS);

`ifdef AXIL_WSTRB_EN
    always_comb begin
        wmask = '0;
        for (int b = 0; b < int'(STRB_W); b++) begin
            wmask[b*8 +: 8] = {8{wstrb_q[b]}};
        end
    end
`else
    assign wmask = '1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, capture of AW/W, response and ready generation.
    always_comb begin
        state_d   = state;
        aw_held_d = aw_held;
        w_held_d  = w_held;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
`ifdef AXIL_WSTRB_EN
        wstrb_d   = wstrb_q;
`endif
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        reg_we    = '0;

        unique case (state)
            IDLE: begin
                if (bus.awvalid && awready_q) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = bus.awaddr;
                end
                if (bus.wvalid && wready_q) begin
                    w_held_d = 1'b1;
                    wdata_d  = bus.wdata;
`ifdef AXIL_WSTRB_EN
                    wstrb_d  = bus.wstrb;
`endif
                end
                if (aw_held_d && w_held_d) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                for (int i = 0; i < int'(NUM_REGS); i++) begin
                    reg_we[i] = legal && (32'(idx) == 32'(i));
                end
                bresp_d  = legal ? RESP_OKAY : RESP_SLVERR;
                bvalid_d = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                if (bus.bready) begin
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Readies are registered, so they look at where the FSM is heading.
        awready_d = (state_d == IDLE) && !aw_held_d;
        wready_d  = (state_d == IDLE) && !w_held_d;
    end

    // Channel holding registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            aw_held   <= aw_held_d;
            w_held    <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

`ifdef AXIL_WSTRB_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wstrb_q <= '0;
        end else begin
            wstrb_q <= wstrb_d;
        end
    end
`endif

    // Register bank: masked read-modify-write of the selected word.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (reg_we[i]) begin
                    regs_q[i] <= (regs_q[i] & ~wmask) | (wdata_q & wmask);
                end
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_regs_out
        assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_axil_wr_slave.sv
// Directed testbench for axil_wr_slave; expected values are hand-computed.
// Build with +define+AXIL_WSTRB_EN to exercise the byte-strobe variant.
module tb_axil_wr_slave;

    logic         clk = 1'b0;
    logic         reset;
    logic [511:0] regs_out;
    logic [31:0]  exp_regs [16];
    int           total = 0;
    int           bad   = 0;

    axil_wr_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    axil_wr_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .regs_out (regs_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] flat();
        logic [511:0] f;
        for (int i = 0; i < 16; i++) f[i*32 +: 32] = exp_regs[i];
        return f;
    endfunction

    // Drives AW and W together with bready high; reports bresp, latency and
    // the bank as seen in the first bvalid cycle, then completes the B beat.
    task automatic send_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                              output logic [1:0] resp, output int lat, output logic [511:0] snap);
        bus.awaddr = a; bus.awvalid = 1'b1;
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        bus.bready = 1'b1;
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        lat = -1; resp = 2'b11; snap = '0;
        for (int c = 1; c <= 20; c++) begin
            if (bus.bvalid === 1'b1) begin
                lat = c; resp = bus.bresp; snap = regs_out;
                break;
            end
            step();
        end
        if (lat > 0) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 1'b0; bus.bready = 1'b0;
        for (int i = 0; i < 16; i++) exp_regs[i] = '0;
        step(); step();
        total++; if (bus.awready !== 1'b0) begin bad++; $display("FAIL reset_awready got=%b exp=0", bus.awready); end
        total++; if (bus.wready !== 1'b0) begin bad++; $display("FAIL reset_wready got=%b exp=0", bus.wready); end
        total++; if (bus.bvalid !== 1'b0) begin bad++; $display("FAIL reset_bvalid got=%b exp=0", bus.bvalid); end
        total++; if (bus.bresp !== 2'b00) begin bad++; $display("FAIL reset_bresp got=%b exp=00", bus.bresp); end
        total++; if (regs_out !== 512'd0) begin bad++; $display("FAIL reset_regs got=%h exp=0", regs_out); end
        reset = 1'b0;
        step();
        total++; if (bus.awready !== 1'b1) begin bad++; $display("FAIL post_reset_awready got=%b exp=1", bus.awready); end
        total++; if (bus.wready !== 1'b1) begin bad++; $display("FAIL post_reset_wready got=%b exp=1", bus.wready); end
    endtask

    task automatic test_same_cycle();
        bus.awaddr = 8'h04; bus.awvalid = 1'b1;
        bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        bus.bready = 1'b1;
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        total++; if (bus.awready !== 1'b0) begin bad++; $display("FAIL same_commit_awready got=%b exp=0", bus.awready); end
        total++; if (bus.wready !== 1'b0) begin bad++; $display("FAIL same_commit_wready got=%b exp=0", bus.wready); end
        total++; if (bus.bvalid !== 1'b0) begin bad++; $display("FAIL same_commit_bvalid got=%b exp=0", bus.bvalid); end
        step();
        exp_regs[1] = 32'hDEADBEEF;
        total++; if (bus.bvalid !== 1'b1) begin bad++; $display("FAIL same_bvalid got=%b exp=1", bus.bvalid); end
        total++; if (bus.bresp !== 2'b00) begin bad++; $display("FAIL same_bresp got=%b exp=00", bus.bresp); end
        total++; if (regs_out !== flat()) begin bad++; $display("FAIL same_regs got=%h exp=%h", regs_out, flat()); end
        step();
        total++; if (bus.bvalid !== 1'b0) begin bad++; $display("FAIL same_bvalid_drop got=%b exp=0", bus.bvalid); end
        total++; if (bus.awready !== 1'b1 || bus.wready !== 1'b1) begin bad++;
            $display("FAIL same_readies_back got=%b%b exp=11", bus.awready, bus.wready); end
    endtask

    task automatic test_w_first();
        bus.bready = 1'b1;
        bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        step();
        bus.wvalid = 1'b0;
        total++; if (bus.wready !== 1'b0) begin bad++; $display("FAIL wfirst_wready got=%b exp=0", bus.wready); end
        total++; if (bus.awready !== 1'b1) begin bad++; $display("FAIL wfirst_awready got=%b exp=1", bus.awready); end
        step();
        total++; if (bus.bvalid !== 1'b0) begin bad++; $display("FAIL wfirst_early_bvalid got=%b exp=0", bus.bvalid); end
        total++; if (regs_out !== flat()) begin bad++; $display("FAIL wfirst_early_regs got=%h exp=%h", regs_out, flat()); end
        bus.awaddr = 8'h08; bus.awvalid = 1'b1;
        step();
        bus.awvalid = 1'b0;
        total++; if (bus.bvalid !== 1'b0) begin bad++; $display("FAIL wfirst_commit_bvalid got=%b exp=0", bus.bvalid); end
        step();
        exp_regs[2] = 32'h12345678;
        total++; if (bus.bvalid !== 1'b1) begin bad++; $display("FAIL wfirst_bvalid got=%b exp=1", bus.bvalid); end
        total++; if (bus.bresp !== 2'b00) begin bad++; $display("FAIL wfirst_bresp got=%b exp=00", bus.bresp); end
        total++; if (regs_out !== flat()) begin bad++; $display("FAIL wfirst_regs got=%h exp=%h", regs_out, flat()); end
        step();
    endtask

    task automatic test_illegal();
        logic [1:0]   r;
        int           l;
        logic [511:0] s;
        logic [7:0]   addrs [2];
        addrs[0] = 8'h40; addrs[1] = 8'h05;
        for (int k = 0; k < 2; k++) begin
            send_write(addrs[k], 32'hBADC0FFE, 4'hF, r, l, s);
            total++; if (l !== 2) begin bad++; $display("FAIL illegal_lat addr=%h got=%0d exp=2", addrs[k], l); end
            total++; if (r !== 2'b10) begin bad++; $display("FAIL illegal_bresp addr=%h got=%b exp=10", addrs[k], r); end
            total++; if (s !== flat()) begin bad++; $display("FAIL illegal_regs addr=%h got=%h exp=%h", addrs[k], s, flat()); end
        end
    endtask

    task automatic test_backpressure();
        bus.bready = 1'b0;
        bus.awaddr = 8'h14; bus.awvalid = 1'b1;
        bus.wdata = 32'hA5A55A5A; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        step();
        exp_regs[5] = 32'hA5A55A5A;
        total++; if (regs_out !== flat()) begin bad++; $display("FAIL bp_regs got=%h exp=%h", regs_out, flat()); end
        for (int c = 0; c < 5; c++) begin
            total++; if (bus.bvalid !== 1'b1) begin bad++; $display("FAIL bp_bvalid cyc=%0d got=%b exp=1", c, bus.bvalid); end
            total++; if (bus.bresp !== 2'b00) begin bad++; $display("FAIL bp_bresp cyc=%0d got=%b exp=00", c, bus.bresp); end
            total++; if (bus.awready !== 1'b0 || bus.wready !== 1'b0) begin bad++;
                $display("FAIL bp_readies cyc=%0d got=%b%b exp=00", c, bus.awready, bus.wready); end
            step();
        end
        bus.bready = 1'b1;
        step();
        total++; if (bus.bvalid !== 1'b0) begin bad++; $display("FAIL bp_bvalid_drop got=%b exp=0", bus.bvalid); end
        total++; if (bus.awready !== 1'b1 || bus.wready !== 1'b1) begin bad++;
            $display("FAIL bp_readies_back got=%b%b exp=11", bus.awready, bus.wready); end
    endtask

    task automatic test_wstrb();
        logic [1:0]   r;
        int           l;
        logic [511:0] s;
        send_write(8'h0C, 32'hFFFFFFFF, 4'hF, r, l, s);
        exp_regs[3] = 32'hFFFFFFFF;
        total++; if (s !== flat()) begin bad++; $display("FAIL strb_fill got=%h exp=%h", s, flat()); end
        send_write(8'h0C, 32'h00000000, 4'b0101, r, l, s);
`ifdef AXIL_WSTRB_EN
        exp_regs[3] = 32'hFF00FF00;
`else
        exp_regs[3] = 32'h00000000;
`endif
        total++; if (r !== 2'b00) begin bad++; $display("FAIL strb_bresp got=%b exp=00", r); end
        total++; if (s !== flat()) begin bad++; $display("FAIL strb_partial got=%h exp=%h", s, flat()); end
        send_write(8'h0C, 32'h12345678, 4'b0000, r, l, s);
`ifndef AXIL_WSTRB_EN
        exp_regs[3] = 32'h12345678;
`endif
        total++; if (r !== 2'b00) begin bad++; $display("FAIL strb0_bresp got=%b exp=00", r); end
        total++; if (s !== flat()) begin bad++; $display("FAIL strb0_regs got=%h exp=%h", s, flat()); end
    endtask

    task automatic test_reset_mid();
        logic [1:0]   r;
        int           l;
        logic [511:0] s;
        // Reset while holding the response.
        bus.bready = 1'b0;
        bus.awaddr = 8'h18; bus.awvalid = 1'b1;
        bus.wdata = 32'h11112222; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        step();
        total++; if (bus.bvalid !== 1'b1) begin bad++; $display("FAIL rmid_pre_bvalid got=%b exp=1", bus.bvalid); end
        reset = 1'b1;
        step();
        for (int i = 0; i < 16; i++) exp_regs[i] = '0;
        total++; if (bus.bvalid !== 1'b0) begin bad++; $display("FAIL rmid_bvalid got=%b exp=0", bus.bvalid); end
        total++; if (bus.awready !== 1'b0 || bus.wready !== 1'b0) begin bad++;
            $display("FAIL rmid_readies got=%b%b exp=00", bus.awready, bus.wready); end
        total++; if (regs_out !== flat()) begin bad++; $display("FAIL rmid_regs got=%h exp=%h", regs_out, flat()); end
        reset = 1'b0;
        step();
        // Reset landing on the commit cycle must not write.
        bus.awaddr = 8'h1C; bus.awvalid = 1'b1;
        bus.wdata = 32'h33334444; bus.wvalid = 1'b1;
        step();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        reset = 1'b1;
        step();
        total++; if (regs_out !== flat()) begin bad++; $display("FAIL rcommit_regs got=%h exp=%h", regs_out, flat()); end
        total++; if (bus.bvalid !== 1'b0) begin bad++; $display("FAIL rcommit_bvalid got=%b exp=0", bus.bvalid); end
        reset = 1'b0;
        step();
        total++; if (bus.awready !== 1'b1 || bus.wready !== 1'b1) begin bad++;
            $display("FAIL rmid_readies_back got=%b%b exp=11", bus.awready, bus.wready); end
        send_write(8'h18, 32'hCAFEF00D, 4'hF, r, l, s);
        exp_regs[6] = 32'hCAFEF00D;
        total++; if (l !== 2) begin bad++; $display("FAIL rmid_after_lat got=%0d exp=2", l); end
        total++; if (r !== 2'b00) begin bad++; $display("FAIL rmid_after_bresp got=%b exp=00", r); end
        total++; if (s !== flat()) begin bad++; $display("FAIL rmid_after_regs got=%h exp=%h", s, flat()); end
    endtask

    initial begin
        test_reset();
        test_same_cycle();
        test_w_first();
        test_illegal();
        test_backpressure();
        test_wstrb();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
